// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte sources.
// Optional `UART_TX_ARB_FIXED_PRIO_EN: requester 0 always wins; the rest rotate.
//
// state     | meaning
// IDLE      | arbitrate pending requests while the transmitter is idle
// LOAD      | byte loaded, pulse tx_start
// WAIT_BUSY | wait for tx_busy to rise, count towards timeout
// WAIT_DONE | frame in progress, wait for tx_busy to fall
module uart_tx_arbiter #(
   parameter int NUM_REQ      = 4,
   parameter int BUSY_TIMEOUT = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NUM_REQ-1:0]   req_valid,
   input  logic [8*NUM_REQ-1:0] req_data,
   output logic [NUM_REQ-1:0]   req_ack,
   output logic [7:0]           tx_data,
   output logic                 tx_load,
   output logic                 tx_start,
   input  logic                 tx_busy,
   output logic                 err_timeout,
   input  logic                 err_clr,
   output logic [2:0]           grant_idx
);

   typedef enum logic [1:0] {IDLE, LOAD, WAIT_BUSY, WAIT_DONE} state_t;

   state_t               state;
   logic [2:0]           ptr;
   logic [2:0]           ptr_next;
   logic [2:0]           winner;
   logic                 found;
   logic [7:0]           win_byte;
   logic [7:0]           cnt;
   logic [NUM_REQ-1:0]   cand;
   logic [NUM_REQ-1:0]   win_onehot;

   // Two passes: first valid at or above the pointer, else the lowest valid (wrap).
   always_comb begin
      cand   = req_valid;
      found  = 1'b0;
      winner = 3'd0;
`ifdef UART_TX_ARB_FIXED_PRIO_EN
      cand[0] = 1'b0;
`endif
      for (int j = 0; j < NUM_REQ; j++) begin
         if (!found && cand[j] && (j >= int'(ptr))) begin
            found  = 1'b1;
            winner = 3'(j);
         end
      end
      for (int j = 0; j < NUM_REQ; j++) begin
         if (!found && cand[j]) begin
            found  = 1'b1;
            winner = 3'(j);
         end
      end
`ifdef UART_TX_ARB_FIXED_PRIO_EN
      if (req_valid[0]) begin
         found  = 1'b1;
         winner = 3'd0;
      end
`endif
   end

   always_comb begin
      win_byte   = 8'h00;
      win_onehot = '0;
      for (int j = 0; j < NUM_REQ; j++) begin
         if (winner == 3'(j)) begin
            win_byte      = req_data[8*j +: 8];
            win_onehot[j] = 1'b1;
         end
      end
   end

   // In fixed-priority mode the pointer only rotates over requesters 1..NUM_REQ-1.
   always_comb begin
`ifdef UART_TX_ARB_FIXED_PRIO_EN
      if (winner == 3'd0)
         ptr_next = ptr;
      else if (winner == 3'(NUM_REQ-1))
         ptr_next = 3'd1;
      else
         ptr_next = winner + 3'd1;
`else
      if (winner == 3'(NUM_REQ-1))
         ptr_next = 3'd0;
      else
         ptr_next = winner + 3'd1;
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         ptr         <= 3'd0;
         cnt         <= 8'd0;
         req_ack     <= '0;
         tx_data     <= 8'h00;
         tx_load     <= 1'b0;
         tx_start    <= 1'b0;
         err_timeout <= 1'b0;
         grant_idx   <= 3'd0;
      end else begin
         req_ack  <= '0;
         tx_load  <= 1'b0;
         tx_start <= 1'b0;
         if (err_clr)
            err_timeout <= 1'b0;
         case (state)
            IDLE: begin
               if (found && !tx_busy) begin
                  tx_data   <= win_byte;
                  tx_load   <= 1'b1;
                  req_ack   <= win_onehot;
                  grant_idx <= winner;
                  ptr       <= ptr_next;
                  state     <= LOAD;
               end
            end
            LOAD: begin
               tx_start <= 1'b1;
               cnt      <= 8'd0;
               state    <= WAIT_BUSY;
            end
            WAIT_BUSY: begin
               if (tx_busy) begin
                  state <= WAIT_DONE;
               end else begin
                  cnt <= cnt + 8'd1;
                  // Set after the clear above so a coincident timeout wins.
                  if (cnt == 8'(BUSY_TIMEOUT-1)) begin
                     err_timeout <= 1'b1;
                     state       <= IDLE;
                  end
               end
            end
            WAIT_DONE: begin
               if (!tx_busy)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: stimulus queues expected grants, a
// forked monitor pops and compares on every tx_load.
module tb_uart_tx_arbiter;
   localparam int N = 4;
   localparam int T = 16;

   logic           clk = 1'b0;
   logic           rst;
   logic [N-1:0]   req_valid;
   logic [8*N-1:0] req_data;
   logic [N-1:0]   req_ack;
   logic [7:0]     tx_data;
   logic           tx_load;
   logic           tx_start;
   logic           tx_busy;
   logic           err_timeout;
   logic           err_clr;
   logic [2:0]     grant_idx;

   int tests = 0;
   int fails = 0;
   logic [10:0] exp_q[$];

   uart_tx_arbiter #(.NUM_REQ(N), .BUSY_TIMEOUT(T)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
      .req_ack(req_ack), .tx_data(tx_data), .tx_load(tx_load),
      .tx_start(tx_start), .tx_busy(tx_busy), .err_timeout(err_timeout),
      .err_clr(err_clr), .grant_idx(grant_idx)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int req);
      tests++;
      if (act != req) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic monitor();
      logic [10:0] e;
      logic        prev_load;
      prev_load = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            prev_load = 1'b0;
         end else begin
            if (tx_load) begin
               if (exp_q.size() == 0) begin
                  tests++;
                  fails++;
                  $display("FAIL unexpected_grant: got grant to %0d with no expected grant queued", grant_idx);
               end else begin
                  e = exp_q.pop_front();
                  check("grant_idx", int'(grant_idx), int'(e[10:8]));
                  check("tx_data", int'(tx_data), int'(e[7:0]));
                  check("req_ack", int'(req_ack), 1 << e[10:8]);
               end
            end else if (req_ack != '0) begin
               check("stray_ack", int'(req_ack), 0);
            end
            if (tx_start || prev_load)
               check("start_after_load", int'(tx_start), int'(prev_load));
            prev_load = tx_load;
         end
      end
   endtask

   task automatic wait_start();
      int k;
      k = 0;
      while (!tx_start && k < 60) begin
         tick(1);
         k++;
      end
      check("start_seen", int'(tx_start), 1);
   endtask

   task automatic serve_frame(input int hold);
      wait_start();
      tick(1);
      tx_busy = 1'b1;
      tick(hold);
      tx_busy = 1'b0;
      tick(2);
   endtask

   task automatic do_reset();
      rst       = 1'b1;
      req_valid = '0;
      tx_busy   = 1'b0;
      err_clr   = 1'b0;
      tick(2);
      rst = 1'b0;
      tick(1);
   endtask

   function automatic logic [10:0] exp_of(input int idx);
      logic [7:0] b;
      case (idx)
         0: b = 8'h11;
         1: b = 8'h22;
         2: b = 8'hA5;
         default: b = 8'h44;
      endcase
      return {3'(idx), b};
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int acks;
      rst       = 1'b1;
      req_valid = '0;
      req_data  = {8'h44, 8'hA5, 8'h22, 8'h11};
      tx_busy   = 1'b0;
      err_clr   = 1'b0;
      fork
         monitor();
      join_none
      tick(2);
      check("rst_outputs", int'({req_ack, tx_data, tx_load, tx_start, err_timeout, grant_idx}), 0);
      rst = 1'b0;
      tick(1);

      // Single request from requester 2, exact latency.
      req_valid = 4'b0100;
      exp_q.push_back(exp_of(2));
      tick(1);
      check("t1_ack_n1", int'(req_ack), 4'b0100);
      check("t1_data_n1", int'(tx_data), 8'hA5);
      check("t1_start_n1", int'(tx_start), 0);
      req_valid = '0;
      tick(1);
      check("t1_start_n2", int'(tx_start), 1);
      check("t1_grant_idx", int'(grant_idx), 2);
      tick(2);
      tx_busy = 1'b1;
      tick(10);
      tx_busy   = 1'b0;
      req_valid = 4'b0001;
      exp_q.push_back(exp_of(0));
      tick(1);
      check("t1_no_grant_in_done", int'(req_ack), 0);
      tick(1);
      check("t1_idle_regrant", int'(req_ack), 4'b0001);
      req_valid = '0;
      serve_frame(3);

      // Rotation over all four requesters.
      do_reset();
      req_valid = 4'b1111;
      for (int f = 0; f < 8; f++) exp_q.push_back(exp_of(f % 4));
      for (int f = 0; f < 8; f++) begin
         wait_start();
         if (f == 7) req_valid = '0;
         tick(1);
         tx_busy = 1'b1;
         tick(3);
         tx_busy = 1'b0;
         tick(1);
      end
      tick(3);
      check("rot_queue_drained", exp_q.size(), 0);

      // Timeout, sticky flag, clear, then normal service.
      do_reset();
      req_valid = 4'b0001;
      exp_q.push_back(exp_of(0));
      wait_start();
      req_valid = '0;
      tick(T-1);
      check("to_before", int'(err_timeout), 0);
      tick(1);
      check("to_at", int'(err_timeout), 1);
      tick(3);
      check("to_sticky", int'(err_timeout), 1);
      err_clr = 1'b1;
      tick(1);
      err_clr = 1'b0;
      check("to_cleared", int'(err_timeout), 0);
      req_valid = 4'b0010;
      exp_q.push_back(exp_of(1));
      wait_start();
      req_valid = '0;
      tick(1);
      tx_busy = 1'b1;
      tick(4);
      tx_busy = 1'b0;
      tick(2);
      check("to_normal_frame", int'(err_timeout), 0);

      // err_clr held across a timeout: set wins, then the clear takes effect.
      req_valid = 4'b0100;
      err_clr   = 1'b1;
      exp_q.push_back(exp_of(2));
      wait_start();
      req_valid = '0;
      tick(T);
      check("to_set_wins", int'(err_timeout), 1);
      tick(1);
      check("to_clr_after_set", int'(err_timeout), 0);
      err_clr = 1'b0;

      // Reset during WAIT_DONE.
      do_reset();
      req_valid = 4'b1111;
      exp_q.push_back(exp_of(0));
      wait_start();
      tick(1);
      tx_busy = 1'b1;
      tick(3);
      rst = 1'b1;
      #1;
      check("rst_mid_outputs", int'({req_ack, tx_data, tx_load, tx_start, err_timeout, grant_idx}), 0);
      tx_busy = 1'b0;
      tick(2);
      exp_q.push_back(exp_of(0));
      rst = 1'b0;
      tick(1);
      check("rst_first_grant0", int'(req_ack), 4'b0001);
      req_valid = '0;
      serve_frame(3);

      // tx_busy high in IDLE blocks granting.
      do_reset();
      tx_busy   = 1'b1;
      req_valid = 4'b0001;
      acks      = 0;
      repeat (6) begin
         tick(1);
         if (req_ack != '0) acks++;
      end
      check("blk_no_ack", acks, 0);
      exp_q.push_back(exp_of(0));
      tx_busy = 1'b0;
      tick(1);
      check("blk_grant", int'(req_ack), 4'b0001);
      req_valid = '0;
      serve_frame(3);

`ifdef UART_TX_ARB_FIXED_PRIO_EN
      // Requester 0 dominates; requester 2 is served once 0 drops.
      do_reset();
      req_valid = 4'b0101;
      for (int f = 0; f < 3; f++) exp_q.push_back(exp_of(0));
      for (int f = 0; f < 3; f++) begin
         wait_start();
         if (f == 2) begin
            req_valid = 4'b0100;
            exp_q.push_back(exp_of(2));
         end
         tick(1);
         tx_busy = 1'b1;
         tick(3);
         tx_busy = 1'b0;
         tick(1);
      end
      wait_start();
      req_valid = '0;
      check("fp_grant2", int'(grant_idx), 2);
      tick(1);
      tx_busy = 1'b1;
      tick(3);
      tx_busy = 1'b0;
      tick(2);
`endif

      tick(3);
      check("queue_drained", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares one UART transmitter between `NUM_REQ` byte sources. The block arbitrates pending requests round-robin, loads the winning byte into the transmitter's data register and pulses the start strobe. It then tracks the transmitter's busy flag until the frame completes. It sits between the requesting blocks (CPU store path, debug streamer, …) and the UART transmit control/datapath.

## Interface
- `NUM_REQ`, default 4: number of requesters; legal range 2–8.
- `BUSY_TIMEOUT`, default 16: cycles allowed between `tx_start` and `tx_busy` rising; legal range 2–255.
- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  NUM_REQ  per-requester byte pending.
- `req_data`  in  8*NUM_REQ  requester i's byte on bits [8i+7:8i].
- `req_ack`  out  NUM_REQ  one-cycle pulse: byte of requester i accepted.
- `tx_data`  out  8  byte presented to the transmitter data register.
- `tx_load`  out  1  one-cycle pulse: transmitter loads `tx_data`.
- `tx_start`  out  1  one-cycle pulse: transmitter begins the frame (byte ready).
- `tx_busy`  in  1  transmitter frame in progress.
- `err_timeout`  out  1  sticky: `tx_busy` never rose after a start.
- `err_clr`  in  1  clears `err_timeout`.
- `grant_idx`  out  3  index of the most recently granted requester.

## Operation
- Reset: state IDLE, rotate pointer 0, all outputs 0 (`req_ack`, `tx_data`, `tx_load`, `tx_start`, `err_timeout`, `grant_idx`).
- All outputs are registered.
- Requester rule: hold `req_valid` and `req_data` stable until `req_ack`. Dropping `req_valid` before `req_ack` withdraws the request with no side effect.
- FSM states:
  - IDLE: if any `req_valid` and `tx_busy`=0, select the winner and go to LOAD. On that edge:
    - `tx_data` ← winner's byte
    - `tx_load`=1
    - `req_ack[winner]`=1
    - `grant_idx` ← winner
    - pointer ← (winner+1) mod NUM_REQ
  - Round-robin selection: the first asserted `req_valid` searching upward from the pointer, wrapping at NUM_REQ-1 → 0.
  - LOAD: `tx_start`=1 for one cycle. Clear the timeout counter. Go to WAIT_BUSY.
  - WAIT_BUSY:
    - If `tx_busy`=1, go to WAIT_DONE.
    - Otherwise increment the counter. On the cycle the counter reaches BUSY_TIMEOUT, set `err_timeout` and go to IDLE.
  - WAIT_DONE: on `tx_busy`=0, go to IDLE.
  - Illegal/default state: go to IDLE.
- `tx_data` holds its value until the next grant.
- `err_clr` and a timeout in the same cycle: set wins.
- Counter is 8 bits, reset to 0 on entering WAIT_BUSY. It never wraps, because the timeout fires first.
- Reset mid-frame: return to IDLE immediately and abandon the in-flight byte. The requester has already been acked and is not re-served.

## Timing
- Grant latency: `req_valid` sampled high in IDLE at edge N gives `req_ack`/`tx_load`/`tx_data` high in cycle N+1 and `tx_start` high in cycle N+2.
- `tx_busy` must rise within BUSY_TIMEOUT cycles after the `tx_start` cycle.
- Minimum spacing between consecutive grants: 3 cycles plus the time `tx_busy` stays high.
- Arbitration happens in IDLE only. Requests arriving during a frame wait.
- `tx_busy`=1 while in IDLE (e.g. transmitter still running after a reset) blocks granting.

## Configuration
- `UART_TX_ARB_FIXED_PRIO_EN` defined: requester 0 wins whenever its `req_valid` is high. Requesters 1..NUM_REQ-1 rotate round-robin among themselves, and the pointer is not updated on a requester-0 grant.
- Undefined: pure round-robin over all NUM_REQ requesters as described above.

## Test plan
- Single request: NUM_REQ=4, `req_valid`=4'b0100, byte 8'hA5, `tx_busy` rises 2 cycles after start and is held for 10 cycles → `req_ack`=4'b0100 and `tx_data`=8'hA5 at N+1, `tx_start` at N+2, `grant_idx`=2, back to IDLE when `tx_busy` falls.
- Rotation: all four requesters held valid for 8 frames → grant order 0,1,2,3,0,1,2,3, with exactly one `req_ack` pulse per frame.
- Timeout: `tx_busy` held 0 after `tx_start` → `err_timeout`=1 exactly BUSY_TIMEOUT cycles after the `tx_start` cycle; `err_clr` pulse → 0; next request is served normally.
- Reset mid-frame: assert `rst` during WAIT_DONE → all outputs 0 immediately; after release the pointer is 0, so with all valid the first grant is to 0.
- Blocking: `tx_busy`=1 while in IDLE and `req_valid`=4'b0001 → no `req_ack` until `tx_busy`=0, then grant on the next edge.
- With `UART_TX_ARB_FIXED_PRIO_EN`: requesters 0 and 2 held valid → requester 0 granted every frame; drop 0 → requester 2 granted.
